// File: rtl/ps_ddr_receiver_if.sv
// AXI3 read-address / read-data channel bundle between ps_ddr_receiver and a PS HP port.
// master : drives AR channel and RREADY (the receiver)
// slave  : drives ARREADY and the R channel (the HP port or a bench model)
// Write channels are not carried; they are tied off at the HP port.
interface ps_ddr_receiver_if;
  logic [5:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [3:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARLOCK;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic [3:0]  M_AXI_ARQOS;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [5:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/ps_ddr_receiver.sv
// AXI3 read master: on an i_start pulse in IDLE, fetches one INCR burst of 1-16 32-bit words
// from PS DDR and streams them out on a registered o_data/o_data_valid strobe. Each
// transaction ends with a one-cycle o_done; o_err is sticky until the next accepted start.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_start           request pulse, only sampled in IDLE
//   i_ddr_addr        burst start byte address (bits [1:0] ignored)
//   i_burst_len       beats minus 1
//   o_data/_valid     registered read word and its one-cycle strobe
//   o_busy, o_done    state != IDLE, state == DONE
//   o_err             error status of the last transaction
//   o_state           IDLE=0, ADDR_READ=1, DATA_READ=2, DONE=3
//   m_axi             AR and R channels (master modport)
//
// Optional: define PS_DDR_RX_TIMEOUT_EN to add a watchdog that aborts a transaction after
// TIMEOUT_CYC cycles without an AR or R handshake.
module ps_ddr_receiver #(
  parameter int unsigned AXI_ID      = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [31:0]           i_ddr_addr,
  input  logic [3:0]            i_burst_len,
  output logic [31:0]           o_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_state,
  ps_ddr_receiver_if.master     m_axi
);

  localparam logic [5:0] AxiId = AXI_ID[5:0];

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAddrRead = 3'd1,
    StDataRead = 3'd2,
    StDone     = 3'd3
  } state_e;

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        err_q, err_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;

  // Word index of the last beat within its 4KB page; bit 10 set means the burst crosses.
  logic [10:0] page_end;
  logic        crosses_4k;
  logic        ar_hs, r_hs, last_beat, beat_bad;

  assign page_end   = {1'b0, i_ddr_addr[11:2]} + {7'd0, i_burst_len};
  assign crosses_4k = page_end[10];
  assign ar_hs      = arvalid_q & m_axi.M_AXI_ARREADY;
  assign r_hs       = rready_q & m_axi.M_AXI_RVALID;
  assign last_beat  = (beat_q == len_q);
  assign beat_bad   = m_axi.M_AXI_RRESP[1] | (m_axi.M_AXI_RID != AxiId);

  logic unused_bits;
  assign unused_bits = ^{i_ddr_addr[1:0], m_axi.M_AXI_RRESP[0]};

`ifdef PS_DDR_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    err_d        = err_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    len_d        = len_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          addr_d = {i_ddr_addr[31:2], 2'b00};
          len_d  = i_burst_len;
          if (crosses_4k) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d     = 1'b0;
            arvalid_d = 1'b1;
            state_d   = StAddrRead;
          end
        end
      end
      StAddrRead: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = 4'd0;
          state_d   = StDataRead;
        end
      end
      StDataRead: begin
        if (r_hs) begin
          data_d       = m_axi.M_AXI_RDATA;
          data_valid_d = 1'b1;
          beat_d       = beat_q + 4'd1;
          if (beat_bad) err_d = 1'b1;
          if (m_axi.M_AXI_RLAST || last_beat) begin
            // RLAST must coincide exactly with beat len_q.
            if (m_axi.M_AXI_RLAST != last_beat) err_d = 1'b1;
            rready_d = 1'b0;
            state_d  = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef PS_DDR_RX_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == StAddrRead || state_q == StDataRead) begin
      if (ar_hs || r_hs) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        // Recovery only: dropping ARVALID before ARREADY breaks AXI rules by design.
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        err_d     = 1'b1;
        state_d   = StDone;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      beat_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
`ifdef PS_DDR_RX_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
`ifdef PS_DDR_RX_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_busy       = (state_q != StIdle);
  assign o_done       = (state_q == StDone);
  assign o_err        = err_q;
  assign o_state      = state_q;

  assign m_axi.M_AXI_ARID    = AxiId;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARLEN   = len_q;
  assign m_axi.M_AXI_ARSIZE  = 3'b010;
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARLOCK  = 1'b0;
  assign m_axi.M_AXI_ARCACHE = 4'b0011;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARQOS   = 4'd0;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule
